// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver:
// active-low segment patterns, blank/off codes, digit count.
package sseg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

endpackage

// File: rtl/sseg_decoder.sv
// Hex digit to active-low {g,f,e,d,c,b,a} segment pattern.
// Purely combinational.
module sseg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (code)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/sseg_scan_driver.sv
// 4-digit multiplexed seven-segment driver, frame-coherent latching.
// Optional SSEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num3,
    input  logic [3:0] num2,
    input  logic [3:0] num1,
    input  logic [3:0] num0,
    input  logic [3:0] dp_mask,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PLAST = PW'(REFRESH_DIV - 1);
    localparam logic [1:0] IDX_LAST = 2'(NUM_DIGITS - 1);

    logic [PW-1:0] pcnt;
    logic          tick;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          wrap;

    logic [NUM_DIGITS-1:0][3:0] sh_num;
    logic [NUM_DIGITS-1:0][3:0] live_num;
    logic [NUM_DIGITS-1:0][3:0] eff_num;
    logic [NUM_DIGITS-1:0]      sh_dp;
    logic [NUM_DIGITS-1:0]      eff_dp;

    logic [3:0] sel;
    logic [6:0] dec;
    logic       blank;

    assign tick     = (pcnt == PLAST);
    assign idx_nxt  = idx + 2'd1;
    assign wrap     = (idx == IDX_LAST);
    assign live_num = {num3, num2, num1, num0};

    // At the wrap tick slot 0 must see the values being captured now
    assign eff_num = wrap ? live_num : sh_num;
    assign eff_dp  = wrap ? dp_mask : sh_dp;
    assign sel     = eff_num[idx_nxt];

    sseg_decoder u_dec (
        .code (sel),
        .seg  (dec)
    );

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic hi_zero;

    always_comb begin
        blank   = 1'b0;
        hi_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            hi_zero = hi_zero & (eff_num[i] == 4'd0);
            if (idx_nxt == 2'(i)) blank = hi_zero;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= IDX_LAST;
            sh_num <= '0;
            sh_dp  <= '0;
            an     <= AN_OFF;
            seg    <= SEG_BLANK;
            dp     <= 1'b1;
        end else if (tick) begin
            idx <= idx_nxt;
            if (wrap) begin
                sh_num <= live_num;
                sh_dp  <= dp_mask;
            end
            an  <= ~(4'b0001 << idx_nxt);
            seg <= blank ? SEG_BLANK : dec;
            dp  <= ~eff_dp[idx_nxt];
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized bench for sseg_scan_driver against a slot-timing model.
// Model derives digit slots from edge count since reset release.
module tb_sseg_scan_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] num3 = '0;
    logic [3:0] num2 = '0;
    logic [3:0] num1 = '0;
    logic [3:0] num0 = '0;
    logic [3:0] dp_mask = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    sseg_scan_driver #(.REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .num3    (num3),
        .num2    (num2),
        .num1    (num1),
        .num0    (num0),
        .dp_mask (dp_mask),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] dtab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: slot number = edges since release / DIV
    int         t = 0;
    int         cur_k = -1;
    logic [3:0] snap [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0] snap_dp = '0;
    logic [3:0] exp_an = 4'hF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;
    logic       chk_en = 1'b0;

    function automatic logic blank_at(input int k);
        logic b;
        b = 1'b0;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        if (k > 0) begin
            b = 1'b1;
            for (int j = k; j < 4; j++)
                if (snap[j] != 4'd0) b = 1'b0;
        end
`endif
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t = 0;
            cur_k = -1;
            exp_an = 4'hF;
            exp_seg = 7'h7F;
            exp_dp = 1'b1;
        end else begin
            t++;
            if (t % DIV == 0) begin
                cur_k = (t / DIV - 1) % 4;
                if (cur_k == 0) begin
                    snap[0] = num0;
                    snap[1] = num1;
                    snap[2] = num2;
                    snap[3] = num3;
                    snap_dp = dp_mask;
                end
                exp_an = 4'hF;
                exp_an[cur_k] = 1'b0;
                exp_seg = blank_at(cur_k) ? 7'h7F : dtab[snap[cur_k]];
                exp_dp = ~snap_dp[cur_k];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("dp", 32'(dp), 32'(exp_dp));
        end
    end

    task automatic wait_k(input int k);
        for (int i = 0; i < 40 && cur_k != k; i++) @(negedge clk);
        check("wait_slot", 32'(cur_k), 32'(k));
    endtask

    task automatic set_nums(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        num3 = a;
        num2 = b;
        num1 = c;
        num0 = d;
    endtask

    task automatic release_and_check_first();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("an_dark", 32'(an), 32'h0F);
        end
        @(negedge clk);
        check("an_first", 32'(an), 32'b1110);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        repeat (10) @(negedge clk);

        set_nums(4'd5, 4'd3, 4'd1, 4'd0);
        dp_mask = 4'b0000;
        release_and_check_first();
        repeat (28) @(negedge clk);

        wait_k(1);
        num0 = 4'd9;
        wait_k(0);
        check("next_d0", 32'(seg), 32'b0010000);
        repeat (16) @(negedge clk);

        set_nums(4'd8, 4'd8, 4'd8, 4'd8);
        dp_mask = 4'b0100;
        repeat (36) @(negedge clk);

        set_nums(4'd0, 4'd0, 4'd1, 4'd0);
        dp_mask = 4'b0000;
        repeat (36) @(negedge clk);

        repeat (400) begin
            @(negedge clk);
            if ($urandom_range(5) == 0) begin
                set_nums(4'($urandom), 4'($urandom),
                         4'($urandom), 4'($urandom));
                dp_mask = 4'($urandom);
            end
        end

        wait_k(2);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", 32'(an), 32'h0F);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        repeat (10) @(negedge clk);
        set_nums(4'd5, 4'd3, 4'd1, 4'd0);
        dp_mask = 4'b0000;
        release_and_check_first();
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
